serial_add_sub: RTL and testbench
=================================

SERIAL_ADD_SUB -- requirements
Module: serial_add_sub

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits; legal values 2..32.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 start  input  1  request to begin an operation; sampled only in IDLE.
REQ-005 M  input  1  operation select: 0 = A+B, 1 = A-B.
REQ-006 A  input  WIDTH  operand A, unsigned or two's complement.
REQ-007 B  input  WIDTH  operand B, unsigned or two's complement.
REQ-008 busy  output  1  high while the bit-serial computation runs (RUN state).
REQ-009 done  output  1  one-cycle pulse marking that result, Ts and ovf are valid.
REQ-010 result  output  WIDTH  sum or difference, modulo 2^WIDTH.
REQ-011 Ts  output  1  final carry-out (M=0) or final borrow-out (M=1).
REQ-012 ovf  output  1  two's-complement overflow flag.

Function
REQ-013 The block SHALL be an FSM with exactly three states: IDLE, RUN and DONE.
REQ-014 In IDLE with start=1, the next edge SHALL capture A, B and M into internal registers, clear the step counter and the transport flop t, and move to RUN.
REQ-015 Changes on A, B and M after capture SHALL have no effect on the operation in progress.
REQ-016 RUN SHALL process one bit per cycle, LSB first, for exactly WIDTH cycles, indexed i = 0..WIDTH-1.
REQ-017 Each step SHALL compute s_i = a_i ^ b_i ^ t.
REQ-018 When M=0, each step SHALL set t <= a_i&b_i | a_i&t | b_i&t.
REQ-019 When M=1, each step SHALL set t <= ~a_i&b_i | ~a_i&t | b_i&t.
REQ-020 Each step SHALL shift s_i into the result shift register so that bit i lands at result[i] after the last step.
REQ-021 At the step i = WIDTH-1, the block SHALL record ovf = t_before_step ^ t_after_step (same rule in both modes) and Ts = t_after_step.
REQ-022 The edge that performs step WIDTH-1 SHALL move the FSM to DONE.
REQ-023 done SHALL be 1 only while in DONE, which lasts exactly one cycle, and the FSM then returns to IDLE.
REQ-024 Latency: if start is accepted at edge k, done SHALL be high in the cycle following edge k+WIDTH.
REQ-025 busy SHALL be 1 exactly in RUN (WIDTH cycles) and 0 in IDLE and DONE.
REQ-026 result, Ts and ovf SHALL hold their values from the last completed operation until the next operation reaches DONE.
REQ-027 These outputs SHALL NOT expose partial values during RUN; they update only on the transition into DONE.
REQ-028 start while in RUN or DONE SHALL be ignored, with no queuing.
REQ-029 Back-to-back operations are legal: start=1 in the IDLE cycle immediately after DONE SHALL be accepted.

Reset
REQ-030 While rst=1, state SHALL be IDLE and busy, done, result, Ts, ovf, t and the counter SHALL all be 0, independent of clk.
REQ-031 rst asserted during RUN SHALL abort the operation with no done pulse; outputs return to 0 and a new start is accepted on the first edge after rst falls.

Verification (WIDTH=8)
REQ-032 M=0, A=0x3C, B=0x05, start pulse -> busy for 8 cycles; done pulse at k+8; result=0x41, Ts=0, ovf=0.
REQ-033 M=0, A=0xFF, B=0x01 -> result=0x00, Ts=1, ovf=0; a second case M=0, A=0x7F, B=0x01 -> result=0x80, Ts=0, ovf=1.
REQ-034 M=1, A=0x05, B=0x07 -> result=0xFE, Ts=1, ovf=0; a second case M=1, A=0x80, B=0x01 -> result=0x7F, Ts=0, ovf=1.
REQ-035 Start 0x10+0x20, then during RUN drive start=1 with A=0xFF and change B -> exactly one done pulse; result=0x30; no second operation starts.
REQ-036 Assert rst in RUN cycle 4 of 0x3C+0x05 -> all outputs are 0 immediately with no done pulse; after release, 0x01+0x01 -> result=0x02.
REQ-037 Two back-to-back operations (start in the IDLE cycle after DONE) -> two done pulses 9 edges apart; the first result holds until the second DONE.

Source files
------------

// File: rtl/serial_add_sub_if.sv
// ---------------------------------------------------------------------------
// serial_add_sub_if
//   Bundles the operation request and the result of serial_add_sub.
//
//   Handshake: start is a request level sampled on the rising clock edge only
//   while the block is idle; a request seen in any other state is dropped, not
//   queued. There is no backpressure. busy is high while bits are being
//   processed. done is a one-cycle strobe, and result/Ts/ovf are valid while it
//   is high. They then hold their value until the next done.
//
//   Signals:
//     start  master->slave  begin an operation (taken only when idle)
//     M      master->slave  0 = A+B, 1 = A-B
//     A, B   master->slave  operands, WIDTH bits
//     busy   slave->master  computation in progress
//     done   slave->master  one-cycle completion strobe
//     result slave->master  sum/difference modulo 2^WIDTH
//     Ts     slave->master  final carry-out (add) or borrow-out (subtract)
//     ovf    slave->master  two's-complement overflow
// ---------------------------------------------------------------------------
interface serial_add_sub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             M;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             Ts;
    logic             ovf;

    modport master (
        output start, M, A, B,
        input  busy, done, result, Ts, ovf
    );

    modport slave (
        input  start, M, A, B,
        output busy, done, result, Ts, ovf
    );
endinterface

// File: rtl/serial_add_sub.sv
// ---------------------------------------------------------------------------
// serial_add_sub
//   Bit-serial adder/subtractor. It processes one bit per clock, LSB first,
//   and takes WIDTH cycles per operation. A single transport flop t carries the
//   carry when adding and the borrow when subtracting.
//
//   Ports:
//     clk      rising-edge clock
//     rst      asynchronous, active-high reset
//     bus      serial_add_sub_if.slave (start/M/A/B in, busy/done/result/Ts/ovf out)
//     state_o  current FSM state (0 = IDLE, 1 = RUN, 2 = DONE), for observation
// ---------------------------------------------------------------------------
module serial_add_sub #(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    serial_add_sub_if.slave       bus,
    output logic [1:0]            state_o
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             m_q;
    logic             t_q;
    logic [CW-1:0]    cnt_q;
    // Holds the bits produced so far. The final bit is joined on the last
    // step, so WIDTH-1 flops are enough.
    logic [WIDTH-2:0] sum_q;
    logic [WIDTH-1:0] result_q;
    logic             ts_q;
    logic             ovf_q;
    logic             busy_q;
    logic             done_q;

    logic             a_bit;
    logic             b_bit;
    logic             s_d;
    logic             t_d;
    logic [WIDTH-1:0] sum_d;
    logic             last_step;

    // The operand registers shift right, so bit i is at position 0 during step i.
    assign a_bit     = a_q[0];
    assign b_bit     = b_q[0];
    assign s_d       = a_bit ^ b_bit ^ t_q;
    // Add uses the majority carry. Subtract uses the borrow form, which is the
    // majority function with a inverted.
    assign t_d       = m_q ? ((~a_bit & b_bit) | (~a_bit & t_q) | (b_bit & t_q))
                           : (( a_bit & b_bit) | ( a_bit & t_q) | (b_bit & t_q));
    // The new bit enters at the MSB. After WIDTH steps, bit i is in position i.
    assign sum_d     = {s_d, sum_q};
    assign last_step = (cnt_q == CW'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            m_q      <= 1'b0;
            t_q      <= 1'b0;
            cnt_q    <= '0;
            sum_q    <= '0;
            result_q <= '0;
            ts_q     <= 1'b0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        a_q     <= bus.A;
                        b_q     <= bus.B;
                        m_q     <= bus.M;
                        t_q     <= 1'b0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    a_q   <= a_q >> 1;
                    b_q   <= b_q >> 1;
                    t_q   <= t_d;
                    sum_q <= sum_d[WIDTH-1:1];
                    cnt_q <= cnt_q + CW'(1);
                    if (last_step) begin
                        // The visible outputs change only here. Overflow is the
                        // carry/borrow into the MSB XOR the carry/borrow out of it.
                        result_q <= sum_d;
                        ts_q     <= t_d;
                        ovf_q    <= t_q ^ t_d;
                        cnt_q    <= '0;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.Ts     = ts_q;
    assign bus.ovf    = ovf_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_serial_add_sub.sv
module tb_serial_add_sub;

    localparam int W  = 8;
    localparam int EW = W + 2;   // {result, Ts, ovf}

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] state_w;

    int total    = 0;
    int bad      = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int start_cyc = 0;
    int done_at   = 0;

    logic [EW-1:0] exp_q[$];
    logic [W-1:0]  last_res = '0;

    serial_add_sub_if #(.WIDTH(W)) bus ();

    serial_add_sub #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .state_o (state_w)
    );

    // clock / cycle bookkeeping
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (bus.done === 1'b1) done_cnt <= done_cnt + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model built from plain integer arithmetic.
    function automatic logic [EW-1:0] model(input logic m, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] r;
        logic       ov;
        if (!m) begin
            r  = {1'b0, a} + {1'b0, b};
            ov = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
        end else begin
            r  = {1'b0, a} - {1'b0, b};
            ov = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
        end
        return {r[W-1:0], r[W], ov};
    endfunction

    // Called at a negedge. Start is sampled on the next edge.
    task automatic issue(input logic m, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [EW-1:0] exp, input bit push);
        bus.M     = m;
        bus.A     = a;
        bus.B     = b;
        bus.start = 1'b1;
        if (push) exp_q.push_back(exp);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        start_cyc = cyc;
    endtask

    // Waits for done, checks busy length, latency and the result, then one more cycle.
    task automatic wait_done(input string tag);
        int            n      = 0;
        int            busy_n = 0;
        bit            got    = 0;
        bit            hold_ok = 1;
        logic [EW-1:0] e;
        while (!got && n <= 3 * W) begin
            if (bus.done === 1'b1) begin
                got = 1;
            end else begin
                if (bus.busy === 1'b1) busy_n++;
                if (bus.result !== last_res) hold_ok = 0;
                @(posedge clk);
                #1;
                n++;
            end
        end
        bus.start = 1'b0;   // release any start still held, so nothing is taken after DONE
        check({tag, "_done_seen"}, 64'(got), 64'd1);
        check({tag, "_hold_in_run"}, 64'(hold_ok), 64'd1);
        if (got) begin
            done_at = cyc;
            check({tag, "_latency"}, 64'(cyc - start_cyc), 64'(W));
            check({tag, "_busy_cycles"}, 64'(busy_n), 64'(W));
            check({tag, "_busy_in_done"}, 64'(bus.busy), 64'd0);
            check({tag, "_state_done"}, 64'(state_w), 64'd2);
            check({tag, "_sb_nonempty"}, 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check({tag, "_result"}, 64'(bus.result), 64'(e[EW-1:2]));
                check({tag, "_ts"}, 64'(bus.Ts), 64'(e[1]));
                check({tag, "_ovf"}, 64'(bus.ovf), 64'(e[0]));
                last_res = e[EW-1:2];
            end
            @(posedge clk);
            #1;
            check({tag, "_done_pulse_end"}, 64'(bus.done), 64'd0);
            check({tag, "_state_idle"}, 64'(state_w), 64'd0);
            check({tag, "_result_held"}, 64'(bus.result), 64'(last_res));
        end
    endtask

    initial begin
        int            d0;
        int            gap_ref;
        bit            quiet;
        logic          rm;
        logic [W-1:0]  ra;
        logic [W-1:0]  rb;

        bus.start = 1'b0;
        bus.M     = 1'b0;
        bus.A     = '0;
        bus.B     = '0;

        // Reset is applied before any clock edge, so the clear must be asynchronous.
        #1 rst = 1'b1;
        #2;
        check("rst_busy",   64'(bus.busy),   64'd0);
        check("rst_done",   64'(bus.done),   64'd0);
        check("rst_result", 64'(bus.result), 64'd0);
        check("rst_ts",     64'(bus.Ts),     64'd0);
        check("rst_ovf",    64'(bus.ovf),    64'd0);
        check("rst_state",  64'(state_w),    64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed arithmetic cases with fixed expected values.
        @(negedge clk); issue(1'b0, 8'h3C, 8'h05, {8'h41, 1'b0, 1'b0}, 1); wait_done("add_3c_05");
        @(negedge clk); issue(1'b0, 8'hFF, 8'h01, {8'h00, 1'b1, 1'b0}, 1); wait_done("add_ff_01");
        @(negedge clk); issue(1'b0, 8'h7F, 8'h01, {8'h80, 1'b0, 1'b1}, 1); wait_done("add_7f_01");
        @(negedge clk); issue(1'b1, 8'h05, 8'h07, {8'hFE, 1'b1, 1'b0}, 1); wait_done("sub_05_07");
        @(negedge clk); issue(1'b1, 8'h80, 8'h01, {8'h7F, 1'b0, 1'b1}, 1); wait_done("sub_80_01");

        // A start during RUN, with the operands changed, must be ignored.
        d0 = done_cnt;
        @(negedge clk); issue(1'b0, 8'h10, 8'h20, {8'h30, 1'b0, 1'b0}, 1);
        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = 8'hFF;
        bus.B     = 8'h77;
        wait_done("ignore_start");
        quiet = 1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (bus.busy !== 1'b0 || bus.done !== 1'b0) quiet = 0;
        end
        check("ignore_no_second_op", 64'(quiet), 64'd1);
        check("ignore_one_done", 64'(done_cnt - d0), 64'd1);
        check("ignore_result_kept", 64'(bus.result), 64'h30);

        // Reset during the fourth RUN cycle aborts the operation without a done pulse.
        d0 = done_cnt;
        @(negedge clk); issue(1'b0, 8'h3C, 8'h05, '0, 0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_busy",   64'(bus.busy),   64'd0);
        check("abort_done",   64'(bus.done),   64'd0);
        check("abort_result", 64'(bus.result), 64'd0);
        check("abort_ts",     64'(bus.Ts),     64'd0);
        check("abort_ovf",    64'(bus.ovf),    64'd0);
        check("abort_state",  64'(state_w),    64'd0);
        last_res = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("abort_no_done", 64'(done_cnt - d0), 64'd0);
        rst = 1'b0;
        issue(1'b0, 8'h01, 8'h01, {8'h02, 1'b0, 1'b0}, 1);   // start accepted on the first edge after release
        wait_done("after_abort");

        // Back-to-back: the second start is in the IDLE cycle right after DONE.
        // With done at edge k+8 and the next start accepted at edge k+10, the
        // second done follows edge k+18. That puts 9 edges between the two
        // pulses, so the done samples are 10 cycles apart.
        @(negedge clk); issue(1'b0, 8'h12, 8'h34, model(1'b0, 8'h12, 8'h34), 1);
        wait_done("b2b_first");
        gap_ref = done_at;
        @(negedge clk); issue(1'b1, 8'h34, 8'h12, model(1'b1, 8'h34, 8'h12), 1);
        wait_done("b2b_second");
        check("b2b_done_gap", 64'(done_at - gap_ref), 64'(W + 2));

        // Random operands, checked against the model.
        for (int i = 0; i < 8; i++) begin
            rm = 1'($urandom_range(0, 1));
            ra = W'($urandom_range(0, 255));
            rb = W'($urandom_range(0, 255));
            @(negedge clk); issue(rm, ra, rb, model(rm, ra, rb), 1);
            wait_done("rand");
        end

        check("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
